// File: rtl/npu_config_sequencer_pkg.sv
// npu_cfg_pkg: shared definitions for the NPU configuration sequencer.
//   - opcode constants for the 26-bit command word
//   - bit positions of the opcode / addr / data fields
//   - FSM state encoding and the state_t type exposed for debug
package npu_cfg_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_WAIT  = 2'b10;
    localparam logic [1:0] OP_RUN   = 2'b11;

    localparam int OP_HI   = 25;
    localparam int OP_LO   = 24;
    localparam int ADDR_HI = 23;
    localparam int ADDR_LO = 18;
    localparam int DATA_HI = 17;
    localparam int DATA_LO = 0;

    localparam int ADDR_W  = ADDR_HI - ADDR_LO + 1;
    localparam int FIELD_W = DATA_HI - DATA_LO + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_POP    = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_START  = 3'd4;
    localparam logic [2:0] ST_RUN    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_POP    = ST_POP,
        S_DECODE = ST_DECODE,
        S_WAIT   = ST_WAIT,
        S_START  = ST_START,
        S_RUN    = ST_RUN
    } state_t;

endpackage

// File: rtl/npu_config_sequencer_if.sv
// npu_cfg_if: bus bundle between the sequencer, the config FIFO, the config
// register bank and the NPU start/done handshake.
//   fifo_dout/fifo_empty/fifo_rd_en : standard-read (non-FWFT) FIFO port
//   cfg_we/cfg_addr/cfg_data         : config register write port
//   npu_start/npu_done               : compute start pulse and completion
//
// Handshake rules: fifo_rd_en is a one-cycle strobe issued only while
// fifo_empty was low; the word appears on fifo_dout the cycle after the
// strobe is sampled. cfg_we qualifies cfg_addr/cfg_data for exactly one
// cycle. npu_start is a one-cycle pulse; the first high cycle of npu_done
// after it completes the job (level or pulse both work).
import npu_cfg_pkg::*;

interface npu_cfg_if #(
    parameter int DATA_W = 26
);
    logic [DATA_W-1:0]  fifo_dout;
    logic               fifo_empty;
    logic               fifo_rd_en;
    logic               cfg_we;
    logic [ADDR_W-1:0]  cfg_addr;
    logic [FIELD_W-1:0] cfg_data;
    logic               npu_start;
    logic               npu_done;

    // master: the sequencer
    modport master (
        input  fifo_dout, fifo_empty, npu_done,
        output fifo_rd_en, cfg_we, cfg_addr, cfg_data, npu_start
    );

    // slave: FIFO + register bank + NPU side
    modport slave (
        output fifo_dout, fifo_empty, npu_done,
        input  fifo_rd_en, cfg_we, cfg_addr, cfg_data, npu_start
    );
endinterface

// File: rtl/npu_config_sequencer_timer.sv
// npu_cfg_timer: loadable down-counter with a zero flag.
//   clk, srst : clock, synchronous active-high reset
//   load      : load load_val (takes priority over dec)
//   load_val  : value to load
//   dec       : decrement by one, saturating at zero
//   zero      : count is zero
module npu_cfg_timer #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (srst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/npu_config_sequencer.sv
// npu_config_sequencer: drains command words from the config FIFO and runs
// one action per word: register write, timed wait, or NPU start + wait done.
//   clk, srst   : clock, synchronous active-high reset
//   enable      : permits fetching a new command (looked at only in IDLE)
//   bus         : npu_cfg_if master (FIFO read, config write, NPU handshake)
//   busy        : high in every state except IDLE
//   timeout_err : sticky, set when npu_done does not arrive in time
//   cmd_count   : commands completed, wraps
//   dbg_state   : current FSM state
module npu_config_sequencer
    import npu_cfg_pkg::*;
#(
    parameter int DATA_W       = 26,
    parameter int DONE_TIMEOUT = 1023,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             enable,
    npu_cfg_if.master        bus,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] cmd_count,
    output state_t           dbg_state
);
    localparam logic [FIELD_W-1:0] TO_VAL = FIELD_W'(DONE_TIMEOUT);
    localparam bit TO_EN = (DONE_TIMEOUT != 0);

    state_t state, state_nxt;

    logic [DATA_W-1:0]  word;
    logic [1:0]         op;
    logic [FIELD_W-1:0] field_data;

    logic               rd_q, we_q, start_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [FIELD_W-1:0] data_q;

    logic               rd_nxt, we_nxt, start_nxt;
    logic               cmd_done, err_set;
    logic               tmr_load, tmr_dec, tmr_zero;
    logic [FIELD_W-1:0] tmr_val;

    assign word       = bus.fifo_dout;
    assign op         = word[OP_HI:OP_LO];
    assign field_data = word[DATA_HI:DATA_LO];

    // One timer serves both uses. For WAIT it is loaded with data-1 so the
    // zero flag rises in the last WAIT cycle. For RUN it is loaded with
    // DONE_TIMEOUT in START; reaching zero in RUN is the same moment an
    // up-counter cleared in START would equal DONE_TIMEOUT.
    npu_cfg_timer #(.W(FIELD_W)) u_timer (
        .clk      (clk),
        .srst     (srst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt = state;
        rd_nxt    = 1'b0;
        we_nxt    = 1'b0;
        start_nxt = 1'b0;
        cmd_done  = 1'b0;
        err_set   = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        tmr_val   = '0;
        case (state)
            S_IDLE: begin
                if (enable && !bus.fifo_empty) begin
                    state_nxt = S_POP;
                    rd_nxt    = 1'b1;
                end
            end
            S_POP: begin
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_WRITE: begin
                        we_nxt    = 1'b1;
                        cmd_done  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                    OP_WAIT: begin
                        if (field_data == '0) begin
                            cmd_done  = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            tmr_load  = 1'b1;
                            tmr_val   = field_data - 1'b1;
                            state_nxt = S_WAIT;
                        end
                    end
                    OP_RUN: begin
                        start_nxt = 1'b1;
                        state_nxt = S_START;
                    end
                    default: begin
                        cmd_done  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                endcase
            end
            S_WAIT: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    cmd_done  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_START: begin
                tmr_load  = 1'b1;
                tmr_val   = TO_VAL;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                // done is tested first so it beats a simultaneous timeout
                if (bus.npu_done) begin
                    cmd_done  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (TO_EN && tmr_zero) begin
                    err_set   = 1'b1;
                    cmd_done  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    tmr_dec = TO_EN;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= S_IDLE;
            rd_q        <= 1'b0;
            we_q        <= 1'b0;
            start_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            timeout_err <= 1'b0;
            cmd_count   <= '0;
        end else begin
            state   <= state_nxt;
            rd_q    <= rd_nxt;
            we_q    <= we_nxt;
            start_q <= start_nxt;
            if (we_nxt) begin
                addr_q <= word[ADDR_HI:ADDR_LO];
                data_q <= field_data;
            end
            if (err_set) begin
                timeout_err <= 1'b1;
            end
            if (cmd_done) begin
                cmd_count <= cmd_count + 1'b1;
            end
        end
    end

    assign bus.fifo_rd_en = rd_q;
    assign bus.cfg_we     = we_q;
    assign bus.cfg_addr   = addr_q;
    assign bus.cfg_data   = data_q;
    assign bus.npu_start  = start_q;
    assign busy           = (state != S_IDLE);
    assign dbg_state      = state;
endmodule
